// File: rtl/timer_ctrl.sv
// Timer control sequencer: turns enable/direction/clock-select/reload fields into
// per-cycle load/count strobes for the 8-bit counter and tracks sticky wrap flags.
module timer_ctrl #(
    parameter int PSC_W = 4
) (
    input  logic       clk_in,
    input  logic       presetn,
    input  logic       tcr_en,
    input  logic       tcr_ud,
    input  logic [1:0] tcr_cks,
    input  logic       load_req,
    input  logic       ie_ovf,
    input  logic       ie_udf,
    input  logic       clr_ovf,
    input  logic       clr_udf,
    input  logic [7:0] cnt,
    input  logic [7:0] last_cnt,
    output logic       cnt_load,
    output logic       cnt_en,
    output logic       cnt_ud,
    output logic       ovf_flag,
    output logic       udf_flag,
    output logic       irq
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic [PSC_W-1:0] psc_max;
    logic             counted_q, ud_q;
    logic             ovf_q, udf_q;
    logic             ovf_evt, udf_evt;

    // Compare value is N-1 for N = 2^(tcr_cks+1).
    always_comb begin
        case (tcr_cks)
            2'b00:   psc_max = PSC_W'(1);
            2'b01:   psc_max = PSC_W'(3);
            2'b10:   psc_max = PSC_W'(7);
            default: psc_max = PSC_W'(15);
        endcase
    end

    // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        psc_d    = '0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_req)    state_d = LOAD;
                else if (tcr_en) state_d = RUN;
            end
            LOAD: begin
                cnt_load = 1'b1;
                state_d  = tcr_en ? RUN : IDLE;
            end
            RUN: begin
                // A reload request suppresses a tick that lands in the same cycle.
                if (load_req) begin
                    state_d = LOAD;
                end else begin
                    cnt_en = (psc_q == psc_max);
                    if (!tcr_en) state_d = IDLE;
                    else         psc_d   = cnt_en ? '0 : psc_q + PSC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ovf_evt = counted_q & ~ud_q & (last_cnt == 8'hFF) & (cnt == 8'h00);
    assign udf_evt = counted_q &  ud_q & (last_cnt == 8'h00) & (cnt == 8'hFF);

    // NOTE: state registers use non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            psc_q     <= '0;
            counted_q <= 1'b0;
            ud_q      <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_q     <= psc_d;
            counted_q <= cnt_en;
            ud_q      <= cnt_ud;
            // A new event outranks a clear strobe in the same cycle.
            ovf_q     <= ovf_evt | (ovf_q & ~clr_ovf);
            udf_q     <= udf_evt | (udf_q & ~clr_udf);
        end
    end

    assign cnt_ud   = tcr_ud;
    assign ovf_flag = ovf_q;
    assign udf_flag = udf_q;
    assign irq      = (ovf_q & ie_ovf) | (udf_q & ie_udf);

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: a vector table, directed multi-cycle corner
// cases and a randomized run compared against a cycle-level reference model.
module tb_timer_ctrl;

    localparam int PSC_W = 4;

    logic       clk = 1'b0;
    logic       presetn;
    logic       tcr_en, tcr_ud, load_req;
    logic [1:0] tcr_cks;
    logic       ie_ovf, ie_udf, clr_ovf, clr_udf;
    logic [7:0] cnt, last_cnt;
    logic       cnt_load, cnt_en, cnt_ud, ovf_flag, udf_flag, irq;

    int checks   = 0;
    int failures = 0;

    timer_ctrl #(.PSC_W(PSC_W)) dut (
        .clk_in   (clk),
        .presetn  (presetn),
        .tcr_en   (tcr_en),
        .tcr_ud   (tcr_ud),
        .tcr_cks  (tcr_cks),
        .load_req (load_req),
        .ie_ovf   (ie_ovf),
        .ie_udf   (ie_udf),
        .clr_ovf  (clr_ovf),
        .clr_udf  (clr_udf),
        .cnt      (cnt),
        .last_cnt (last_cnt),
        .cnt_load (cnt_load),
        .cnt_en   (cnt_en),
        .cnt_ud   (cnt_ud),
        .ovf_flag (ovf_flag),
        .udf_flag (udf_flag),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Vector table: {inputs, cnt, last_cnt, expected {load,en,ud,ovf,udf,irq}}
    typedef struct packed {
        logic       en, ld, ud;
        logic [1:0] cks;
        logic       ie_o, ie_u, cl_o, cl_u;
        logic [7:0] c, lc;
        logic [5:0] exp;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input logic en, ld, ud, input logic [1:0] cks,
                                input logic ie_o, ie_u, cl_o, cl_u,
                                input logic [7:0] c, lc, input logic [5:0] exp);
        vec_t v;
        v.en = en; v.ld = ld; v.ud = ud; v.cks = cks;
        v.ie_o = ie_o; v.ie_u = ie_u; v.cl_o = cl_o; v.cl_u = cl_u;
        v.c = c; v.lc = lc; v.exp = exp;
        return v;
    endfunction

    // Reference model: RUN/LOAD activity, cycles elapsed since RUN entry or last tick,
    // and a plain arithmetic model of the 8-bit counter the strobes drive.
    bit         m_run, m_loading, m_counted, m_prev_ud, m_ovf, m_udf;
    int         m_phase;
    bit         model_on = 1'b0;
    logic [7:0] env_cnt = 8'h00, env_last = 8'h00, tdr = 8'h00;
    logic       s_load, s_en, s_ovf, s_udf, s_irq;

    task automatic model_reset();
        m_run = 0; m_loading = 0; m_counted = 0; m_prev_ud = 0;
        m_ovf = 0; m_udf = 0; m_phase = 0;
    endtask

    // One clock cycle: present counter values, compare at the falling edge, advance at the rising edge.
    task automatic cycle_step();
        logic [5:0] exp_v, act_v;
        int         n;
        bit         e_en, e_load, ovf_ev, udf_ev;
        cnt      = env_cnt;
        last_cnt = env_last;
        @(negedge clk);
        n      = 1 << (int'(tcr_cks) + 1);
        e_load = m_loading;
        e_en   = m_run && !load_req && (m_phase == n - 1);
        ovf_ev = m_counted && !m_prev_ud && env_last == 8'hFF && env_cnt == 8'h00;
        udf_ev = m_counted &&  m_prev_ud && env_last == 8'h00 && env_cnt == 8'hFF;
        exp_v  = {e_load, e_en, tcr_ud, m_ovf, m_udf, (m_ovf && ie_ovf) || (m_udf && ie_udf)};
        act_v  = {cnt_load, cnt_en, cnt_ud, ovf_flag, udf_flag, irq};
        s_load = cnt_load; s_en = cnt_en; s_ovf = ovf_flag; s_udf = udf_flag; s_irq = irq;
        if (model_on) check("model {load,en,ud,ovf,udf,irq}", act_v, exp_v);
        check("load_en_exclusive", cnt_load & cnt_en, 0);
        @(posedge clk);
        #1;
        m_counted = e_en;
        m_prev_ud = tcr_ud;
        m_ovf     = ovf_ev || (m_ovf && !clr_ovf);
        m_udf     = udf_ev || (m_udf && !clr_udf);
        if (m_loading) begin
            m_loading = 0; m_run = tcr_en; m_phase = 0;
        end else if (m_run) begin
            if (load_req)     begin m_loading = 1; m_run = 0; m_phase = 0; end
            else if (!tcr_en) begin m_run = 0; m_phase = 0; end
            else              m_phase = e_en ? 0 : (m_phase + 1) % (1 << PSC_W);
        end else begin
            if (load_req)    m_loading = 1;
            else if (tcr_en) m_run = 1;
            m_phase = 0;
        end
        env_last = env_cnt;
        if (e_load)    env_cnt = tdr;
        else if (e_en) env_cnt = tcr_ud ? env_cnt - 8'd1 : env_cnt + 8'd1;
    endtask

    // Steps until cnt_en is seen; k is the 1-based cycle count, or max+1 if it never came.
    task automatic cycles_to_en(input int max, output int k);
        k = max + 1;
        for (int i = 1; i <= max; i++) begin
            cycle_step();
            if (s_en) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic reset_dut();
        presetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        presetn = 1'b1;
        model_reset();
    endtask

    task automatic pulse_load(input logic [7:0] value);
        tdr      = value;
        load_req = 1'b1;
        cycle_step();
        load_req = 1'b0;
    endtask

    initial begin
        int k, pulses;
        // NOTE: stimulus is driven with blocking assignments one time unit after the rising edge.
        presetn = 1'b0; tcr_en = 0; tcr_ud = 0; tcr_cks = 2'b00; load_req = 0;
        ie_ovf = 0; ie_udf = 0; clr_ovf = 0; clr_udf = 0; cnt = 8'h00; last_cnt = 8'h00;
        model_reset();

        tbl.push_back(mk(0,0,0,2'd0, 0,0,0,0, 8'h10,8'h10, 6'b000000));
        tbl.push_back(mk(1,0,0,2'd0, 0,0,0,0, 8'h10,8'h10, 6'b000000));
        tbl.push_back(mk(1,0,0,2'd0, 0,0,0,0, 8'h10,8'h10, 6'b000000));
        tbl.push_back(mk(1,0,0,2'd0, 0,0,0,0, 8'hFF,8'hFE, 6'b010000));
        tbl.push_back(mk(1,0,0,2'd0, 0,0,0,0, 8'h00,8'hFF, 6'b000000));
        tbl.push_back(mk(1,0,1,2'd0, 0,0,0,0, 8'h10,8'h10, 6'b011100));
        tbl.push_back(mk(1,0,1,2'd0, 1,0,0,0, 8'hFF,8'h00, 6'b001101));
        tbl.push_back(mk(1,0,1,2'd0, 0,0,1,0, 8'h10,8'h10, 6'b011110));
        tbl.push_back(mk(1,0,1,2'd0, 0,1,0,0, 8'h10,8'h10, 6'b001011));
        tbl.push_back(mk(0,0,1,2'd0, 0,1,0,1, 8'h10,8'h10, 6'b011011));
        tbl.push_back(mk(0,0,0,2'd0, 0,0,0,0, 8'h10,8'h10, 6'b000000));
        tbl.push_back(mk(1,1,0,2'd0, 0,0,0,0, 8'h10,8'h10, 6'b000000));
        tbl.push_back(mk(1,0,0,2'd0, 0,0,0,0, 8'h10,8'h10, 6'b100000));
        tbl.push_back(mk(1,0,0,2'd0, 0,0,0,0, 8'h10,8'h10, 6'b000000));
        tbl.push_back(mk(1,0,0,2'd0, 0,0,0,0, 8'h10,8'h10, 6'b010000));

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {cnt_load, cnt_en, cnt_ud, ovf_flag, udf_flag, irq}, 6'b0);
        presetn = 1'b1;

        foreach (tbl[i]) begin
            tcr_en = tbl[i].en; load_req = tbl[i].ld; tcr_ud = tbl[i].ud; tcr_cks = tbl[i].cks;
            ie_ovf = tbl[i].ie_o; ie_udf = tbl[i].ie_u; clr_ovf = tbl[i].cl_o; clr_udf = tbl[i].cl_u;
            cnt = tbl[i].c; last_cnt = tbl[i].lc;
            @(negedge clk);
            check($sformatf("table row %0d {load,en,ud,ovf,udf,irq}", i),
                  {cnt_load, cnt_en, cnt_ud, ovf_flag, udf_flag, irq}, tbl[i].exp);
            @(posedge clk);
            #1;
        end
        tcr_en = 0; load_req = 0; tcr_ud = 0; tcr_cks = 2'b00;
        ie_ovf = 0; ie_udf = 0; clr_ovf = 0; clr_udf = 0;
        reset_dut();
        model_on = 1'b1;

        // Tick spacing for /2 and /16 (the divider change takes effect at the next compare).
        tcr_en = 1'b1;
        cycles_to_en(40, k); check("div2_first_tick", k, 3);
        cycles_to_en(40, k); check("div2_period", k, 2);
        tcr_cks = 2'b11;
        cycles_to_en(40, k); check("div16_first_tick", k, 16);
        cycles_to_en(40, k); check("div16_period", k, 16);

        // Reload FE counting up at /2: FE -> FF -> 00 raises the overflow flag.
        tcr_cks = 2'b00; ie_ovf = 1'b1;
        pulse_load(8'hFE);
        cycle_step(); check("ovf_load_strobe", s_load, 1); check("ovf_load_no_en", s_en, 0);
        cycle_step(); check("ovf_run_c1_no_en", s_en, 0);
        cycle_step(); check("ovf_tick_at_fe", s_en, 1);
        cycle_step();
        cycle_step(); check("ovf_tick_at_ff", s_en, 1);
        cycle_step(); check("ovf_not_before_edge", s_ovf, 0);
        cycle_step(); check("ovf_flag_set", s_ovf, 1); check("ovf_irq_enabled", s_irq, 1);
        ie_ovf = 1'b0;
        cycle_step(); check("ovf_irq_masked", s_irq, 0); check("ovf_flag_sticky", s_ovf, 1);

        // Asynchronous reset mid-run with the overflow flag set.
        ie_ovf = 1'b1;
        #2;
        presetn = 1'b0;
        #1;
        check("async_reset_outputs", {cnt_load, cnt_en, cnt_ud, ovf_flag, udf_flag, irq}, 6'b0);
        repeat (2) @(posedge clk);
        #1;
        presetn = 1'b1;
        model_reset();
        cycles_to_en(40, k); check("restart_from_idle", k, 3);

        // Reload coincident with a tick at FF: the reload wins and no overflow appears.
        pulse_load(8'hFF);
        cycle_step();
        cycle_step();
        pulse_load(8'h00); check("tick_suppressed_by_load", s_en, 0);
        cycle_step(); check("coincident_load_strobe", s_load, 1); check("coincident_load_no_en", s_en, 0);
        cycles_to_en(40, k); check("tick_after_reload", k, 2);
        check("no_ovf_from_load", s_ovf, 0);
        cycle_step(); check("no_ovf_from_load_later", s_ovf, 0);

        // Disable while holding 7F at /4: no strobes, then resume after re-enable.
        tcr_cks = 2'b01;
        pulse_load(8'h7F);
        tcr_en = 1'b0;
        cycle_step(); check("freeze_load_strobe", s_load, 1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cycle_step();
            if (s_en) pulses++;
        end
        check("frozen_no_en", pulses, 0);
        check("frozen_cnt_7f", cnt, 8'h7F);
        tcr_en = 1'b1;
        cycles_to_en(40, k); check("resume_after_n", k, 5);

        // Down-count underflow 01 -> 00 -> FF, then set-wins over a same-cycle clear.
        tcr_cks = 2'b00; tcr_ud = 1'b1; ie_udf = 1'b1;
        pulse_load(8'h01);
        cycle_step();
        cycles_to_en(40, k); check("udf_tick_at_01", k, 2);
        cycles_to_en(40, k); check("udf_tick_at_00", k, 2);
        cycle_step(); check("udf_not_before_edge", s_udf, 0);
        cycle_step(); check("udf_flag_set", s_udf, 1); check("udf_no_ovf", s_ovf, 0);
        check("udf_irq", s_irq, 1);
        pulse_load(8'h00);
        cycle_step();
        cycles_to_en(40, k); check("udf2_tick_at_00", k, 2);
        clr_udf = 1'b1;
        cycle_step();
        clr_udf = 1'b0;
        cycle_step(); check("udf_set_wins_over_clear", s_udf, 1);
        clr_udf = 1'b1;
        cycle_step();
        clr_udf = 1'b0;
        cycle_step(); check("udf_cleared", s_udf, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            tcr_en   = ($urandom_range(0, 19) != 0);
            load_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 49) == 0) tcr_cks = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) tcr_ud = ~tcr_ud;
            if ($urandom_range(0, 9) == 0)  ie_ovf = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)  ie_udf = 1'($urandom_range(0, 1));
            clr_ovf = ($urandom_range(0, 15) == 0);
            clr_udf = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 4))
                0:       tdr = 8'h00;
                1:       tdr = 8'h01;
                2:       tdr = 8'hFE;
                3:       tdr = 8'hFF;
                default: tdr = 8'($urandom_range(0, 255));
            endcase
            cycle_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
